ma_mem_ctrl: RTL and testbench

- Memory-access-stage controller. Consumes the MA-side fields of the EX/MA pipeline register and runs loads/stores against the data memory over a request/ready handshake.
- Performs byte-lane steering, sign/zero extension, misalignment detection and timeout detection.
- Drives STALL to freeze IF..EX/MA while an access is outstanding.
- Presents the write-back data for the MA/WB register.

---
 rtl/ma_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_ma_mem_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ma_mem_ctrl.sv
// Memory-access stage controller: issues loads/stores to data memory over a
// request/ready handshake, steers byte lanes, formats loads and flags faults.
module ma_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MA_ADDR,
  input  logic [31:0] MA_WDATA,
  input  logic [1:0]  MA_MR,
  input  logic [1:0]  MA_MW,
  input  logic        MA_LOAD_UNS,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic        STALL,
  output logic [31:0] WB_DATA,
  output logic        LOAD_VALID,
  output logic        ACC_ERR
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] load_reg;
  logic        rd_p1;
  logic [1:0]  size_p1;
  logic [1:0]  lane_p1;
  logic        uns_p1;

  logic        rd_req;
  logic        wr_req;
  logic        acc_any;
  logic        acc_legal;
  logic        misalign;
  logic [1:0]  acc_size;

  function automatic logic [3:0] steer_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b01:   return 4'b0001 << lane;
      2'b10:   return 4'b0011 << lane;
      2'b11:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b01:   return {4{wdata[7:0]}};
      2'b10:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [1:0] size, input logic [1:0] lane,
                                              input logic uns, input logic [31:0] rdata);
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    bs = rdata[{lane, 3'b000} +: 8];
    hs = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b01:   return uns ? {24'b0, bs} : 32'(bs);
      2'b10:   return uns ? {16'b0, hs} : 32'(hs);
      default: return rdata;
    endcase
  endfunction

  // Decode of the EX/MA fields presented this cycle
  always_comb begin
    rd_req    = (MA_MR != 2'b00);
    wr_req    = (MA_MW != 2'b00);
    acc_any   = rd_req | wr_req;
    acc_size  = rd_req ? MA_MR : MA_MW;
    misalign  = ((acc_size == 2'b10) && MA_ADDR[0]) ||
                ((acc_size == 2'b11) && (MA_ADDR[1:0] != 2'b00));
    acc_legal = (rd_req ^ wr_req) && !misalign;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_BE     <= '0;
      MEM_WDATA  <= '0;
      load_reg   <= '0;
      tmo_cnt    <= '0;
      LOAD_VALID <= 1'b0;
      ACC_ERR    <= 1'b0;
      rd_p1      <= 1'b0;
      size_p1    <= '0;
      lane_p1    <= '0;
      uns_p1     <= 1'b0;
    end else begin
      LOAD_VALID <= 1'b0;
      ACC_ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_any) begin
            if (acc_legal) begin
              state     <= BUSY;
              MEM_REQ   <= 1'b1;
              MEM_WE    <= wr_req;
              MEM_ADDR  <= {MA_ADDR[31:2], 2'b00};
              MEM_BE    <= steer_be(acc_size, MA_ADDR[1:0]);
              MEM_WDATA <= wr_req ? steer_wdata(acc_size, MA_WDATA) : '0;
              tmo_cnt   <= '0;
              rd_p1     <= rd_req;
              size_p1   <= acc_size;
              lane_p1   <= MA_ADDR[1:0];
              uns_p1    <= MA_LOAD_UNS;
            end else begin
              state   <= DONE;
              ACC_ERR <= 1'b1;
            end
          end
        end
        // Ready on the final allowed cycle still completes the access
        BUSY: begin
          if (MEM_READY) begin
            MEM_REQ <= 1'b0;
            state   <= DONE;
            if (rd_p1) begin
              load_reg   <= format_load(size_p1, lane_p1, uns_p1, MEM_RDATA);
              LOAD_VALID <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            MEM_REQ <= 1'b0;
            ACC_ERR <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    STALL   = (state == BUSY) || ((state == IDLE) && acc_any);
    WB_DATA = MA_ADDR;
    if (state == DONE) begin
      if (LOAD_VALID)   WB_DATA = load_reg;
      else if (ACC_ERR) WB_DATA = '0;
    end
  end

endmodule

// File: tb/tb_ma_mem_ctrl.sv
// Self-checking bench for ma_mem_ctrl: directed cases plus random accesses
// against an arithmetic reference of lane steering, formatting and timing.
module tb_ma_mem_ctrl;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] MA_ADDR, MA_WDATA;
  logic [1:0]  MA_MR, MA_MW;
  logic        MA_LOAD_UNS;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_READY;
  logic        STALL;
  logic [31:0] WB_DATA;
  logic        LOAD_VALID, ACC_ERR;

  int n_chk = 0;
  int n_err = 0;

  ma_mem_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .MA_ADDR(MA_ADDR), .MA_WDATA(MA_WDATA), .MA_MR(MA_MR), .MA_MW(MA_MW),
    .MA_LOAD_UNS(MA_LOAD_UNS),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY),
    .STALL(STALL), .WB_DATA(WB_DATA), .LOAD_VALID(LOAD_VALID), .ACC_ERR(ACC_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One instruction through MA: memory answers after dly extra cycles (dly>=TMO never answers)
  task automatic run_op(input string tag, input logic [1:0] mr, input logic [1:0] mw,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic uns,
                        input logic [31:0] rdata, input int dly);
    int nb, lane, estall, ereq, stall_n, req_n;
    bit access, ill, tmo, elv, eae, done;
    logic [1:0]  sz;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld, ewb, mask;
    sz     = (mr != 0) ? mr : mw;
    nb     = (sz == 3) ? 4 : (sz == 2) ? 2 : 1;
    lane   = int'(addr[1:0]);
    access = (mr != 0) || (mw != 0);
    ill    = access && (((mr != 0) && (mw != 0)) || ((addr % nb) != 0));
    tmo    = dly >= TMO;
    ebe    = 4'(((1 << nb) - 1) << lane);
    ewd    = 32'h0;
    if (mw != 0)
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 1);
    eld  = (rdata >> (8*lane)) & mask;
    if (!uns && nb < 4 && eld[8*nb-1]) eld = eld | ~mask;
    if (!access)  estall = 0;
    else if (ill) estall = 1;
    else if (tmo) estall = 1 + TMO;
    else          estall = 2 + dly;
    ereq = (access && !ill) ? (tmo ? TMO : dly + 1) : 0;
    elv  = access && !ill && (mr != 0) && !tmo;
    eae  = ill || (access && tmo);
    ewb  = eae ? 32'h0 : elv ? eld : addr;

    @(posedge CLK); #1;
    MA_MR = mr; MA_MW = mw; MA_ADDR = addr; MA_WDATA = wdata; MA_LOAD_UNS = uns;
    MEM_READY = 1'b0; MEM_RDATA = 32'h0;
    stall_n = 0; req_n = 0; done = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge CLK);
      if (MEM_REQ) begin
        req_n++;
        if (req_n == 1) begin
          chk({tag, "_addr"}, MEM_ADDR, addr & 32'hFFFF_FFFC);
          chk({tag, "_be"}, 32'(MEM_BE), 32'(ebe));
          chk({tag, "_we"}, 32'(MEM_WE), 32'(mw != 0));
          chk({tag, "_wdata"}, MEM_WDATA, ewd);
        end
        MEM_READY = (req_n == dly + 1);
        MEM_RDATA = rdata;
      end else begin
        MEM_READY = 1'b0;
      end
      if (STALL) stall_n++;
      else begin
        chk({tag, "_lv"}, 32'(LOAD_VALID), 32'(elv));
        chk({tag, "_err"}, 32'(ACC_ERR), 32'(eae));
        chk({tag, "_wb"}, WB_DATA, ewb);
        done = 1;
        break;
      end
      @(posedge CLK);
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_stall"}, stall_n, estall);
    chk({tag, "_req"}, req_n, ereq);
  endtask

  initial begin
    logic [31:0] r;
    int kind, dly;
    RESET = 1'b1;
    MA_ADDR = 0; MA_WDATA = 0; MA_MR = 0; MA_MW = 0; MA_LOAD_UNS = 0;
    MEM_RDATA = 0; MEM_READY = 0;
    repeat (2) @(negedge CLK);
    chk("rst_req", 32'(MEM_REQ), 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_be", 32'(MEM_BE), 0);
    chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_lv", 32'(LOAD_VALID), 0);
    chk("rst_err", 32'(ACC_ERR), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    run_op("lw",      2'b11, 2'b00, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 0);
    run_op("lb",      2'b01, 2'b00, 32'h103, 32'h0, 1'b0, 32'h80FF1234, 0);
    run_op("lbu",     2'b01, 2'b00, 32'h103, 32'h0, 1'b1, 32'h80FF1234, 1);
    run_op("sh",      2'b00, 2'b10, 32'h202, 32'h0000ABCD, 1'b0, 32'h0, 3);
    run_op("lw_mis",  2'b11, 2'b00, 32'h102, 32'h0, 1'b0, 32'h0, 0);
    run_op("both",    2'b11, 2'b11, 32'h100, 32'h0, 1'b0, 32'h0, 0);
    run_op("lh_odd",  2'b10, 2'b00, 32'h101, 32'h0, 1'b0, 32'h0, 0);
    run_op("tmo",     2'b11, 2'b00, 32'h300, 32'h0, 1'b0, 32'h0, 255);
    run_op("nop",     2'b00, 2'b00, 32'h1234, 32'h0, 1'b0, 32'h0, 0);
    run_op("lw_last", 2'b11, 2'b00, 32'h400, 32'h0, 1'b0, 32'h12345678, TMO - 1);
    run_op("lh_hi",   2'b10, 2'b00, 32'h502, 32'h0, 1'b0, 32'h9ABC0000, 2);
    run_op("sb",      2'b00, 2'b01, 32'h601, 32'h000000A5, 1'b0, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      r    = $urandom();
      kind = $urandom_range(0, 9);
      dly  = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 4);
      case (kind)
        0:       run_op("rnd_nop", 2'b00, 2'b00, r, $urandom(), 1'b0, 32'h0, dly);
        1:       run_op("rnd_both", 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), r,
                        $urandom(), 1'b0, $urandom(), dly);
        2, 3, 4: run_op("rnd_st", 2'b00, 2'($urandom_range(1, 3)), r, $urandom(), 1'b0,
                        32'h0, dly);
        default: run_op("rnd_ld", 2'($urandom_range(1, 3)), 2'b00, r, 32'h0,
                        1'($urandom_range(0, 1)), $urandom(), dly);
      endcase
    end

    // Reset while a load is outstanding, then a stray ready
    @(posedge CLK); #1;
    MA_MR = 2'b11; MA_MW = 2'b00; MA_ADDR = 32'h700;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_busy_req", 32'(MEM_REQ), 1);
    RESET = 1'b1;
    #1;
    chk("mid_rst_req", 32'(MEM_REQ), 0);
    MA_MR = 2'b00;
    @(posedge CLK); #1;
    RESET = 1'b0;
    MEM_READY = 1'b1; MEM_RDATA = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge CLK);
      chk("post_rst_lv", 32'(LOAD_VALID), 0);
      chk("post_rst_req", 32'(MEM_REQ), 0);
    end
    MEM_READY = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
